// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM states, FCS byte index width, CRC-32 constants.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        IFG
    } fcs_state_e;

    localparam int          FCS_IDX_W  = 2;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_R = 32'hEDB8_8320;

    // One byte through the reflected CRC-32 (LSB-first, shift right).
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_fcs_ctrl_if.sv
// Byte stream handshake: data/vld/last forward, rdy backward.
interface eth_tx_fcs_ctrl_if;
    logic [7:0] data;
    logic       vld;
    logic       last;
    logic       rdy;

    modport master (output data, vld, last, input rdy);
    modport slave  (input data, vld, last, output rdy);
endinterface

// File: rtl/eth_tx_fcs_ctrl_crc32.sv
// Byte-serial CRC-32 engine. rst holds the register at the initial value; a
// byte strobed while rst is high is folded in starting from the initial value,
// so the first byte of a frame never loses a cycle.
module crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] seed;
    assign seed = rst ? CRC_INIT : crc;

    // fold in a byte on strobe, otherwise hold or return to the initial value
    always_ff @(posedge clk) begin
        if (vld)      crc <= crc32_byte(seed, data);
        else if (rst) crc <= CRC_INIT;
    end

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet TX FCS controller: passes payload through, optionally pads to a
// minimum length, appends the CRC-32 FCS LSB first, then holds an IFG.
// Padding is compiled in only with ETH_TX_FCS_PAD_EN defined.
module eth_tx_fcs_ctrl
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_CYCLES    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    eth_tx_fcs_ctrl_if.slave  s,
    eth_tx_fcs_ctrl_if.master m
);

    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 2047 || IFG_CYCLES < 0 || IFG_CYCLES > 65535) begin : g_bad_param
        $error("eth_tx_fcs_ctrl: parameter out of range");
    end

    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    fcs_state_e           state;
    logic [31:0]          crc;
    logic [31:0]          fcs_q;
    logic [FCS_IDX_W-1:0] fcs_idx;
    logic                 fcs_ld;
    logic [15:0]          ifg_cnt;
    logic                 s_xfer, m_xfer, feed;

    assign s_xfer = s.vld & s.rdy;
    assign m_xfer = m.vld & m.rdy;
    // payload and pad bytes enter the CRC on their output transfer
    assign feed   = rst_n & m_xfer & (state == IDLE || state == DATA || state == PAD);

    crc32 u_crc (
        .clk  (clk),
        .rst  (~rst_n | (state == IDLE)),
        .vld  (feed),
        .data (m.data),
        .crc  (crc)
    );

`ifdef ETH_TX_FCS_PAD_EN
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
    logic [10:0] cnt, cnt_base, cnt_inc;
    assign cnt_base = (state == IDLE) ? 11'd0 : cnt;
    assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 11'd1;

    // frame byte counter: restarts per frame, saturates at 2047
    always_ff @(posedge clk) begin
        if (!rst_n)             cnt <= '0;
        else if (feed)          cnt <= cnt_inc;
        else if (state == IDLE) cnt <= '0;
    end
`endif

    // output muxing; reset forces plain pass-through so nothing partial leaks
    always_comb begin
        s.rdy  = 1'b0;
        m.vld  = 1'b0;
        m.data = 8'h00;
        m.last = 1'b0;
        if (!rst_n) begin
            s.rdy  = m.rdy;
            m.vld  = s.vld;
            m.data = s.data;
        end else begin
            case (state)
                IDLE, DATA: begin
                    s.rdy  = m.rdy;
                    m.vld  = s.vld;
                    m.data = s.data;
                end
`ifdef ETH_TX_FCS_PAD_EN
                PAD: m.vld = 1'b1;
`endif
                FCS: begin
                    m.vld  = ~fcs_ld;
                    m.data = fcs_q[{fcs_idx, 3'b000} +: 8];
                    m.last = ~fcs_ld & (&fcs_idx);
                end
                default: ;
            endcase
        end
    end

    // frame sequencing; FCS spends one cycle latching the final CRC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            fcs_q   <= '0;
            fcs_idx <= '0;
            fcs_ld  <= 1'b0;
            ifg_cnt <= '0;
        end else begin
            case (state)
                IDLE, DATA: begin
                    if (s_xfer) begin
                        if (s.last) begin
                            fcs_ld  <= 1'b1;
                            fcs_idx <= '0;
`ifdef ETH_TX_FCS_PAD_EN
                            state   <= (cnt_inc < MIN_LEN) ? PAD : FCS;
`else
                            state   <= FCS;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
`ifdef ETH_TX_FCS_PAD_EN
                PAD: begin
                    if (m_xfer && cnt_inc >= MIN_LEN) begin
                        state  <= FCS;
                        fcs_ld <= 1'b1;
                    end
                end
`endif
                FCS: begin
                    if (fcs_ld) begin
                        fcs_q  <= crc ^ CRC_XOROUT;
                        fcs_ld <= 1'b0;
                    end else if (m_xfer) begin
                        if (&fcs_idx) begin
                            state   <= (IFG_CYCLES == 0) ? IDLE : IFG;
                            fcs_idx <= '0;
                            ifg_cnt <= '0;
                        end else begin
                            fcs_idx <= fcs_idx + 1'b1;
                        end
                    end
                end
                IFG: begin
                    if (ifg_cnt == IFG_LAST) state   <= IDLE;
                    else                     ifg_cnt <= ifg_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Directed bench for eth_tx_fcs_ctrl: known-answer FCS, padding, stalls,
// mid-FCS reset and back-to-back IFG spacing.
module tb_eth_tx_fcs_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eth_tx_fcs_ctrl_if s_if ();
    eth_tx_fcs_ctrl_if m_if ();

    eth_tx_fcs_ctrl #(.MIN_FRAME_LEN(60), .IFG_CYCLES(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_if),
        .m     (m_if)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] src_d[$];
    bit         src_l[$];
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] cap_d[$];
    bit         cap_l[$];
    int         gaps[$];

    function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic clr();
        src_d.delete(); src_l.delete();
        exp_d.delete(); exp_l.delete();
        cap_d.delete(); cap_l.delete();
        gaps.delete();
    endtask

    // queue a frame for the source and append its expected output bytes
    task automatic add_frame(input logic [7:0] pl[$]);
        logic [7:0]  f[$];
        logic [31:0] c;
        f = pl;
        foreach (pl[i]) begin
            src_d.push_back(pl[i]);
            src_l.push_back(i == pl.size() - 1);
        end
`ifdef ETH_TX_FCS_PAD_EN
        while (f.size() < 60) f.push_back(8'h00);
`endif
        c = crc_model(f);
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        foreach (f[i]) begin
            exp_d.push_back(f[i]);
            exp_l.push_back(i == f.size() - 1);
        end
    endtask

    // drive queued frames, capture output transfers, measure IFG gaps;
    // rst_at >= 0 pulses reset when that many bytes have been captured
    task automatic run(input bit stall, input bit bubble, input int rst_at, input int budget);
        int         cyc = 0, frames = 0, lasts = 0, gap = 0;
        bit         in_gap = 0, stalled = 0, rst_done = 0;
        logic [8:0] held = '0;
        foreach (src_l[i]) if (src_l[i]) frames++;
        while ((lasts < frames || in_gap) && !rst_done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            rst_n = 1'b1;
            if (rst_at >= 0 && cap_d.size() == rst_at) begin
                rst_n = 1'b0;
                src_d.delete(); src_l.delete();
            end
            s_if.vld  = (src_d.size() > 0) && (!bubble || $urandom_range(0, 3) != 0);
            s_if.data = (src_d.size() > 0) ? src_d[0] : 8'h00;
            s_if.last = (src_d.size() > 0) ? src_l[0] : 1'b0;
            m_if.rdy  = (stall && !in_gap) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_pass", {s_if.rdy, m_if.vld, m_if.last}, {m_if.rdy, s_if.vld, 1'b0});
                rst_done = 1;
            end
            if (stalled && m_if.vld) chk("stall_hold", {m_if.data, m_if.last}, held);
            stalled = m_if.vld && !m_if.rdy;
            held    = {m_if.data, m_if.last};
            if (in_gap) begin
                if (s_if.rdy) begin gaps.push_back(gap); in_gap = 0; end
                else gap++;
            end
            if (s_if.vld && s_if.rdy) begin
                void'(src_d.pop_front());
                void'(src_l.pop_front());
            end
            if (m_if.vld && m_if.rdy) begin
                cap_d.push_back(m_if.data);
                cap_l.push_back(m_if.last);
                if (m_if.last) begin lasts++; in_gap = 1; gap = 0; end
            end
        end
        if (rst_at >= 0) chk("rst_no_last", lasts, 0);
        else             chk("frames_done", lasts, frames);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, cap_d.size(), exp_d.size());
        foreach (exp_d[i]) if (i < cap_d.size()) begin
            chk($sformatf("%s[%0d]", tag, i), cap_d[i], exp_d[i]);
            chk($sformatf("%s_last[%0d]", tag, i), cap_l[i], exp_l[i]);
        end
    endtask

    task automatic chk_gaps(input string tag, input int n);
        chk({tag, "_ifg_n"}, gaps.size(), n);
        foreach (gaps[i]) chk($sformatf("%s_ifg[%0d]", tag, i), gaps[i], 12);
    endtask

`ifndef ETH_TX_FCS_PAD_EN
    task automatic chk_kat(input string tag);
        logic [7:0] k[4];
        k = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_kat[%0d]", tag, i), (cap_d.size() > 9 + i) ? cap_d[9+i] : 8'hXX, k[i]);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p9[$];
        logic [7:0] p64[$];
        logic [7:0] p20[$];
        logic [7:0] p1[$];
        p9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        p1  = '{8'h55};
        for (int i = 0; i < 64; i++) p64.push_back(8'(i * 7 + 3));
        for (int i = 0; i < 20; i++) p20.push_back(8'(8'hC0 ^ i));

        rst_n = 1'b0; s_if.vld = 0; s_if.data = 0; s_if.last = 0; m_if.rdy = 0;

        // pass-through while held in reset
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            s_if.vld  = i[0];
            s_if.last = i[0];
            m_if.rdy  = i[1];
            s_if.data = 8'(8'hA0 + i);
            @(negedge clk);
            chk("rst_hold", {s_if.rdy, m_if.vld, m_if.last, m_if.data},
                            {m_if.rdy, s_if.vld, 1'b0, s_if.data});
        end
        @(posedge clk); #1;
        rst_n = 1'b1; s_if.vld = 0; s_if.last = 0; m_if.rdy = 1;
        @(negedge clk);
        chk("idle_rdy", s_if.rdy, 1);
        chk("idle_vld", m_if.vld, 0);

        // single short frame
        clr(); add_frame(p9); run(0, 0, -1, 500);
        compare("p9");
        chk_gaps("p9", 1);
`ifdef ETH_TX_FCS_PAD_EN
        chk("p9_pad_total", cap_d.size(), 64);
        for (int i = 9; i < 60; i++) chk($sformatf("pad[%0d]", i), (cap_d.size() > i) ? cap_d[i] : 8'hXX, 8'h00);
`else
        chk_kat("p9");
`endif

        // frame already at minimum length
        clr(); add_frame(p64); run(0, 0, -1, 500);
        compare("p64");
        chk("p64_total", cap_d.size(), 68);

        // stalls and source bubbles
        clr(); add_frame(p9); add_frame(p64); add_frame(p1); run(1, 1, -1, 4000);
        compare("stall");

        // reset while the second FCS byte is on the bus
        clr(); add_frame(p9); run(0, 0, exp_d.size() - 3, 500);
        chk("rst_cap_len", cap_d.size(), exp_d.size() - 3);
        clr(); add_frame(p9); run(0, 0, -1, 500);
        compare("after_rst");
`ifndef ETH_TX_FCS_PAD_EN
        chk_kat("after_rst");
`endif

        // back-to-back frames, source always valid
        clr(); add_frame(p9); add_frame(p1); add_frame(p20); run(0, 0, -1, 2000);
        compare("b2b");
        chk_gaps("b2b", 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_tx_fcs_ctrl.md
ETH_TX_FCS_CTRL -- requirements
Module: eth_tx_fcs_ctrl

Interface
REQ-001 Parameter MIN_FRAME_LEN, default 60, minimum frame length in bytes before the FCS.
REQ-002 Parameter IFG_CYCLES, default 12, number of idle cycles enforced after the final FCS byte.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 s_data  input  8  payload byte from the frame source.
REQ-006 s_vld  input  1  s_data valid.
REQ-007 s_last  input  1  s_data is the final payload byte.
REQ-008 s_rdy  output  1  block accepts s_data this cycle.
REQ-009 m_data  output  8  byte toward the MAC transmitter.
REQ-010 m_vld  output  1  m_data valid.
REQ-011 m_last  output  1  m_data is the final FCS byte.
REQ-012 m_rdy  input  1  transmitter accepts m_data this cycle.

Function
REQ-013 The block SHALL implement the FSM IDLE, DATA, PAD, FCS, IFG.
REQ-014 Transfers on both ports SHALL occur only when vld and rdy are both high in the same cycle.
REQ-015 In IDLE and DATA: s_rdy = m_rdy, m_vld = s_vld, m_data = s_data, with zero latency.
REQ-016 In IDLE, the CRC engine SHALL be held in its initial state, so the first accepted byte is the first CRC input.
REQ-017 IDLE -> DATA on the first accepted byte without s_last.
REQ-018 Every accepted payload byte and every emitted pad byte SHALL be fed to the CRC engine in the cycle of its transfer.
REQ-019 An 11-bit byte counter SHALL count accepted payload and pad bytes; it saturates at 2047.
REQ-020 On an accepted byte with s_last, the FSM SHALL go to PAD if (count+1) < MIN_FRAME_LEN, otherwise to FCS.
REQ-021 PAD behaviour:
  - s_rdy = 0.
  - m_vld = 1, m_data = 0x00.
  - Exit to FCS on the transfer that brings count to MIN_FRAME_LEN.
REQ-022 FCS entry: the standard CRC-32 result (reflected, final-inverted) SHALL be registered one cycle after the last CRC input.
  - m_vld is low during that cycle.
REQ-023 FCS output:
  - Four bytes, least-significant byte first.
  - Each byte advances only on transfer.
  - m_last = 1 on the fourth byte.
  - s_rdy = 0 throughout.
REQ-024 After the fourth FCS transfer, the FSM SHALL enter IFG with s_rdy = 0 and m_vld = 0 for IFG_CYCLES cycles, then return to IDLE.
REQ-025 While m_rdy = 0, m_data, m_last and the FCS/PAD position SHALL hold stable.
REQ-026 A one-byte frame (s_last on the first byte in IDLE) SHALL follow REQ-020 directly from IDLE.
REQ-027 s_vld = 0 mid-frame in DATA SHALL leave state, counter and CRC unchanged.

Reset
REQ-028 rst_n = 0 at any clock edge SHALL force:
  - FSM to IDLE.
  - Counter to 0.
  - FCS register to 0.
  - IFG counter to 0.
  - CRC engine to its initial state.
REQ-029 During and after reset: s_rdy = m_rdy, m_vld = s_vld, m_last = 0; no partial frame or FCS is ever resumed.

Configuration
REQ-030 With macro ETH_TX_FCS_PAD_EN defined, padding per REQ-020/REQ-021 SHALL be compiled in.
REQ-031 Without ETH_TX_FCS_PAD_EN, PAD state and MIN_FRAME_LEN logic SHALL be absent, and s_last always leads to FCS.

Structure
REQ-032 The FSM state enum, the FCS byte-index width and the CRC-32 initial/final-XOR constants (0xFFFFFFFF) SHALL reside in the shared package eth_pkg.
REQ-033 The block SHALL instantiate the existing crc32 byte-serial engine as its only sub-module, driving its rst from state and its vld from the transfer strobe.

Verification
REQ-034 Pad off: payload "123456789" (0x31..0x39), m_rdy = 1 -> 9 bytes, then FCS 0x26 0x39 0xF4 0xCB with m_last on 0xCB, then 12 idle cycles.
REQ-035 Pad on: 9-byte frame -> 9 payload bytes, then 51 bytes of 0x00, then 4 FCS bytes equal to the model CRC over the 60 bytes; 64 transfers total.
REQ-036 Pad on: 64-byte frame -> no pad bytes; 68 transfers; FCS matches the model.
REQ-037 m_rdy toggled pseudo-randomly during DATA/PAD/FCS -> byte stream identical to the m_rdy = 1 run; outputs stable while stalled.
REQ-038 rst_n pulsed low during the second FCS byte -> m_last never asserts; next frame "123456789" (pad off) yields 0x26 0x39 0xF4 0xCB.
REQ-039 Back-to-back frames with s_vld held high -> s_rdy low for exactly 12 cycles after each m_last transfer, then the next frame's first byte passes.
